// File: rtl/snpu_pkg.sv
// snpu_pkg: shared opcodes, FSM state encoding and status-byte layout for the SNPU command path.
package snpu_pkg;
    localparam logic [7:0] OP_LOAD   = 8'h1A;
    localparam logic [7:0] OP_RUN    = 8'h2B;
    localparam logic [7:0] OP_CLRERR = 8'h3C;
    localparam int ST_BUSY  = 7;
    localparam int ST_ERR   = 6;
    localparam int ST_STATE = 4;
    localparam int ST_CNT   = 0;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_COUNT = 2'd2,
        S_DATA  = 2'd3
    } state_t;
    function automatic logic [7:0] pack_status(input logic busy, input logic err,
                                               input state_t st, input logic [3:0] cnt);
        logic [7:0] s;
        s = '0;
        s[ST_BUSY] = busy;
        s[ST_ERR] = err;
        s[ST_STATE +: 2] = st;
        s[ST_CNT +: 4] = cnt;
        return s;
    endfunction
endpackage

// File: rtl/snpu_cmd_rx_if.sv
// snpu_cmd_rx_if: host byte-strobe inputs and scratch-write / start / status outputs of the command receiver.
interface snpu_cmd_rx_if #(parameter int ADDR_W = 6);
    logic              ena;
    logic [7:0]        data_in;
    logic              strobe_in;
    logic              core_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              start;
    logic [7:0]        status;
    modport slave (input ena, data_in, strobe_in, core_busy,
                   output wr_en, wr_addr, wr_data, start, status);
    modport master (output ena, data_in, strobe_in, core_busy,
                    input wr_en, wr_addr, wr_data, start, status);
endinterface

// File: rtl/snpu_sync_edge.sv
// snpu_sync_edge: 2-flop synchroniser for an asynchronous pin plus a registered rising-edge pulse.
module snpu_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);
    logic r_s1, r_s2, r_s3, r_valid, r_armed, r_pulse;
    // Armed only once a genuine low sample is seen, so a pin held high across reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_valid <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_async;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= 1'b1;
            r_armed <= r_armed | (r_valid & ~r_s1);
            r_pulse <= r_s2 & ~r_s3 & r_armed;
        end
    end
    assign o_pulse = r_pulse;
endmodule

// File: rtl/snpu_cmd_rx.sv
// snpu_cmd_rx: decodes host command bytes (LOAD/RUN/CLRERR) and streams payload into scratch memory.
module snpu_cmd_rx import snpu_pkg::*; #(
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    snpu_cmd_rx_if.slave bus
);
    logic              w_edge, w_byte;
    logic [7:0]        w_d;
    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr, r_wr_addr;
    logic [7:0]        r_rem, r_wr_data;
    logic              r_err, r_wr_en, r_start;
    logic [3:0]        r_cnt;

    snpu_sync_edge u_strobe (.clk(clk), .rst_n(rst_n), .i_async(bus.strobe_in), .o_pulse(w_edge));

    assign w_byte = w_edge & bus.ena;
    assign w_d    = bus.data_in;

    // Remaining count of 0 wraps through 255 down to 1, giving 256 data bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_rem     <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_start   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_start <= 1'b0;
            if (w_byte) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_d == OP_LOAD) begin
                            r_state <= S_ADDR;
                        end else if (w_d == OP_RUN) begin
                            if (!bus.core_busy) begin
                                r_start <= 1'b1;
                                r_cnt   <= r_cnt + 4'd1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (w_d == OP_CLRERR) begin
                            r_err <= 1'b0;
                            r_cnt <= r_cnt + 4'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        r_ptr   <= w_d[ADDR_W-1:0];
                        r_state <= S_COUNT;
                    end
                    S_COUNT: begin
                        r_rem   <= w_d;
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ptr;
                        r_wr_data <= w_d;
                        r_ptr     <= r_ptr + 1'b1;
                        r_rem     <= r_rem - 8'd1;
                        if (r_rem == 8'd1) begin
                            r_state <= S_IDLE;
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.start   = r_start;
    assign bus.status  = pack_status(bus.core_busy, r_err, r_state, r_cnt);
endmodule

// File: tb/tb_snpu_cmd_rx.sv
// tb_snpu_cmd_rx: randomized command streams checked against a command-level reference model.
module tb_snpu_cmd_rx;
    import snpu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snpu_cmd_rx_if #(.ADDR_W(6)) bus();
    snpu_cmd_rx #(.ADDR_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [13:0] got_wr[$];
    logic [13:0] exp_wr[$];
    int got_start = 0;
    int exp_start = 0;
    int overlap = 0;
    logic m_err = 1'b0;
    logic [3:0] m_cnt = 4'd0;

    always @(posedge clk) begin
        #1;
        if (bus.wr_en === 1'b1) got_wr.push_back({bus.wr_addr, bus.wr_data});
        if (bus.start === 1'b1) got_start++;
        if (bus.wr_en === 1'b1 && bus.start === 1'b1) overlap++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) bus.data_in = b;
        @(negedge clk) bus.strobe_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.strobe_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] addr, input logic [7:0] n);
        int len;
        logic [7:0] d;
        len = (n == 0) ? 256 : int'(n);
        send_byte(OP_LOAD);
        send_byte(addr);
        send_byte(n);
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            exp_wr.push_back({6'((int'(addr) + i) % 64), d});
            send_byte(d);
        end
        m_cnt = 4'((int'(m_cnt) + 1) % 16);
    endtask

    task automatic do_run(input logic busy);
        bus.core_busy = busy;
        send_byte(OP_RUN);
        if (busy) m_err = 1'b1;
        else begin
            exp_start++;
            m_cnt = 4'((int'(m_cnt) + 1) % 16);
        end
    endtask

    task automatic do_clr();
        send_byte(OP_CLRERR);
        m_err = 1'b0;
        m_cnt = 4'((int'(m_cnt) + 1) % 16);
    endtask

    task automatic test_reset();
        bus.ena = 1'b1; bus.core_busy = 1'b0; bus.strobe_in = 1'b1; bus.data_in = 8'h55;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.status !== 8'h00 || bus.wr_en !== 1'b0 || bus.start !== 1'b0)
            begin bad++; $display("FAIL reset_outputs: status=%h wr_en=%b start=%b exp 00/0/0", bus.status, bus.wr_en, bus.start); end
        total++;
        if (bus.wr_addr !== 6'd0 || bus.wr_data !== 8'd0)
            begin bad++; $display("FAIL reset_wr_bus: addr=%h data=%h exp 0/0", bus.wr_addr, bus.wr_data); end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (bus.status !== 8'h00 || got_wr.size() != 0 || got_start != 0)
            begin bad++; $display("FAIL reset_strobe_high: status=%h writes=%0d starts=%0d exp 00/0/0", bus.status, got_wr.size(), got_start); end
        bus.strobe_in = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (bus.status !== 8'h00)
            begin bad++; $display("FAIL reset_strobe_drop: status=%h exp 00", bus.status); end
    endtask

    task automatic test_load_basic();
        logic [7:0] dd [3];
        dd = '{8'hAA, 8'hBB, 8'hCC};
        send_byte(OP_LOAD); send_byte(8'h05); send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back({6'(5 + i), dd[i]});
            send_byte(dd[i]);
        end
        m_cnt = 4'd1;
        total++;
        if (bus.status !== 8'h01)
            begin bad++; $display("FAIL load_basic_status: status=%h exp 01", bus.status); end
        total++;
        if (got_wr.size() != exp_wr.size())
            begin bad++; $display("FAIL load_basic_count: got %0d writes exp %0d", got_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) begin
            total++;
            if (got_wr[i] !== exp_wr[i])
                begin bad++; $display("FAIL load_basic_wr%0d: got %h exp %h", i, got_wr[i], exp_wr[i]); end
        end
    endtask

    task automatic test_wrap();
        got_wr.delete(); exp_wr.delete();
        do_load(8'h3E, 8'd3);
        total++;
        if (got_wr.size() != 3 || got_wr[0][13:8] !== 6'h3E || got_wr[1][13:8] !== 6'h3F || got_wr[2][13:8] !== 6'h00)
            begin bad++; $display("FAIL wrap_addr: writes=%0d exp 3 at 3E,3F,00", got_wr.size()); end
        else foreach (exp_wr[i]) begin
            total++;
            if (got_wr[i] !== exp_wr[i])
                begin bad++; $display("FAIL wrap_wr%0d: got %h exp %h", i, got_wr[i], exp_wr[i]); end
        end
        total++;
        if (bus.status !== {1'b0, m_err, 2'b00, m_cnt} || m_err !== 1'b0)
            begin bad++; $display("FAIL wrap_status: status=%h exp %h", bus.status, {1'b0, m_err, 2'b00, m_cnt}); end
    endtask

    task automatic test_run();
        logic [3:0] obs;
        bus.core_busy = 1'b0;
        @(negedge clk) bus.data_in = OP_RUN;
        @(negedge clk) bus.strobe_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            obs[i] = bus.start;
        end
        @(negedge clk) bus.strobe_in = 1'b0;
        repeat (3) @(negedge clk);
        exp_start++;
        m_cnt = 4'((int'(m_cnt) + 1) % 16);
        total++;
        if (obs !== 4'b1000)
            begin bad++; $display("FAIL run_latency: start per edge k..k+3 got %b exp 1000", obs); end
        total++;
        if (got_start != exp_start)
            begin bad++; $display("FAIL run_start: got %0d exp %0d", got_start, exp_start); end
        do_run(1'b1);
        total++;
        if (got_start != exp_start || bus.status !== {1'b1, 1'b1, 2'b00, m_cnt})
            begin bad++; $display("FAIL run_busy: starts=%0d status=%h exp %0d/%h", got_start, bus.status, exp_start, {1'b1, 1'b1, 2'b00, m_cnt}); end
        bus.core_busy = 1'b0;
        do_clr();
        total++;
        if (bus.status !== {1'b0, 1'b0, 2'b00, m_cnt})
            begin bad++; $display("FAIL clrerr: status=%h exp %h", bus.status, {1'b0, 1'b0, 2'b00, m_cnt}); end
    endtask

    task automatic test_illegal();
        got_wr.delete(); exp_wr.delete();
        send_byte(8'h55);
        m_err = 1'b1;
        total++;
        if (bus.status !== {1'b0, 1'b1, 2'b00, m_cnt})
            begin bad++; $display("FAIL illegal_status: status=%h exp %h", bus.status, {1'b0, 1'b1, 2'b00, m_cnt}); end
        do_load(8'h20, 8'd2);
        total++;
        if (got_wr.size() != 2 || got_wr[0] !== exp_wr[0] || got_wr[1] !== exp_wr[1])
            begin bad++; $display("FAIL illegal_then_load: writes=%0d exp 2", got_wr.size()); end
        total++;
        if (bus.status !== {1'b0, 1'b1, 2'b00, m_cnt})
            begin bad++; $display("FAIL illegal_load_status: status=%h exp %h", bus.status, {1'b0, 1'b1, 2'b00, m_cnt}); end
        do_clr();
    endtask

    task automatic test_ena();
        logic [7:0] d0, d1;
        got_wr.delete(); exp_wr.delete();
        d0 = 8'($urandom); d1 = 8'($urandom);
        send_byte(OP_LOAD); send_byte(8'h10); send_byte(8'd2); send_byte(d0);
        bus.ena = 1'b0;
        send_byte(8'hEE);
        total++;
        if (bus.status[5:4] !== 2'd3 || got_wr.size() != 1)
            begin bad++; $display("FAIL ena_hold: state=%0d writes=%0d exp 3/1", bus.status[5:4], got_wr.size()); end
        bus.ena = 1'b1;
        send_byte(d1);
        exp_wr.push_back({6'h10, d0}); exp_wr.push_back({6'h11, d1});
        m_cnt = 4'((int'(m_cnt) + 1) % 16);
        total++;
        if (got_wr.size() != 2 || got_wr[0] !== exp_wr[0] || got_wr[1] !== exp_wr[1])
            begin bad++; $display("FAIL ena_resume: writes=%0d exp 2 (%h %h)", got_wr.size(), exp_wr[0], exp_wr[1]); end
        total++;
        if (bus.status !== {1'b0, m_err, 2'b00, m_cnt})
            begin bad++; $display("FAIL ena_status: status=%h exp %h", bus.status, {1'b0, m_err, 2'b00, m_cnt}); end
    endtask

    task automatic test_reset_mid();
        got_wr.delete(); exp_wr.delete();
        got_start = 0; exp_start = 0;
        send_byte(OP_LOAD); send_byte(8'h08); send_byte(8'd4);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.status !== 8'h00 || bus.wr_en !== 1'b0 || bus.wr_addr !== 6'd0)
            begin bad++; $display("FAIL reset_mid_immediate: status=%h wr_en=%b addr=%h exp 00/0/0", bus.status, bus.wr_en, bus.wr_addr); end
        m_err = 1'b0; m_cnt = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_run(1'b0);
        total++;
        if (got_wr.size() != 2 || got_start != 1 || bus.status !== 8'h01)
            begin bad++; $display("FAIL reset_mid_after: writes=%0d starts=%0d status=%h exp 2/1/01", got_wr.size(), got_start, bus.status); end
    endtask

    task automatic test_count0();
        got_wr.delete(); exp_wr.delete();
        do_load(8'h30, 8'd0);
        total++;
        if (got_wr.size() != 256)
            begin bad++; $display("FAIL count0_len: got %0d writes exp 256", got_wr.size()); end
        else foreach (exp_wr[i]) if (got_wr[i] !== exp_wr[i]) begin
            total++; bad++;
            $display("FAIL count0_wr%0d: got %h exp %h", i, got_wr[i], exp_wr[i]);
        end
        total++;
        if (bus.status !== {1'b0, m_err, 2'b00, m_cnt})
            begin bad++; $display("FAIL count0_status: status=%h exp %h", bus.status, {1'b0, m_err, 2'b00, m_cnt}); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        got_wr.delete(); exp_wr.delete();
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0: do_load(8'($urandom), 8'($urandom_range(1, 4)));
                1: do_run(1'($urandom));
                2: do_clr();
                default: begin
                    b = 8'($urandom);
                    if (b == OP_LOAD || b == OP_RUN || b == OP_CLRERR) b = 8'h00;
                    send_byte(b);
                    m_err = 1'b1;
                end
            endcase
            total++;
            if (bus.status !== {bus.core_busy, m_err, 2'b00, m_cnt} || got_start != exp_start)
                begin bad++; $display("FAIL random_cmd%0d: status=%h starts=%0d exp %h/%0d", n, bus.status, got_start, {bus.core_busy, m_err, 2'b00, m_cnt}, exp_start); end
            bus.core_busy = 1'b0;
        end
        total++;
        if (got_wr.size() != exp_wr.size())
            begin bad++; $display("FAIL random_wr_count: got %0d exp %0d", got_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) if (got_wr[i] !== exp_wr[i]) begin
            total++; bad++;
            $display("FAIL random_wr%0d: got %h exp %h", i, got_wr[i], exp_wr[i]);
        end
        total++;
        if (overlap != 0)
            begin bad++; $display("FAIL pulse_overlap: got %0d cycles exp 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_wrap();
        test_run();
        test_illegal();
        test_ena();
        test_reset_mid();
        test_count0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/snpu_cmd_rx.md
# snpu_cmd_rx

Host-side command receiver for the SNPU tile: synchronises the asynchronous byte-strobe interface on the dedicated input pins, decodes a small byte-oriented command protocol, and streams weight/activation bytes into the core's scratch memory. Sits directly downstream of the top-level pins (ui_in / uio_in) and upstream of the compute core, to which it issues a one-cycle start pulse. Its status byte is driven back to uo_out.

## Interface
- ADDR_W, 6: scratch-memory address width; addresses wrap modulo 2^ADDR_W.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; strobes are ignored while low.
- data_in  in  8  host byte (ui_in).
- strobe_in  in  1  host byte strobe (uio_in[0]); asynchronous to clk.
- core_busy  in  1  compute core is running.
- wr_en  out  1  scratch write enable, one cycle per data byte.
- wr_addr  out  ADDR_W  scratch write address.
- wr_data  out  8  scratch write data.
- start  out  1  one-cycle pulse launching the core.
- status  out  8  {core_busy, err, state[1:0], cmd_cnt[3:0]} to uo_out.

## Operation
- strobe_in passes a 2-flop synchroniser, then a rising-edge detector; each detected edge with ena=1 consumes exactly one byte of data_in. The edge detector tracks even while ena=0, so ena rising never creates a false edge.
- FSM states (encoding for status[5:4]): IDLE=0, ADDR=1, COUNT=2, DATA=3.
- IDLE, byte 0x1A (LOAD) -> ADDR. Byte 0x2B (RUN): if core_busy=0 pulse start, else set err; stay IDLE. Byte 0x3C (CLRERR): clear err. Any other byte: set err, stay IDLE.
- ADDR: latch byte[ADDR_W-1:0] as write pointer -> COUNT.
- COUNT: latch byte as remaining count; 0 means 256 -> DATA.
- DATA: each byte -> wr_en=1, wr_addr=pointer, wr_data=byte; pointer+1 mod 2^ADDR_W; remaining-1; after the last byte -> IDLE.
- cmd_cnt increments mod 16 on each completed command (LOAD after its last data byte, RUN when start is pulsed, CLRERR); illegal opcodes and rejected RUNs do not count.
- err is sticky; only CLRERR or reset clears it. err never blocks further commands.
- Bytes in ADDR/COUNT/DATA are payload and are never decoded as opcodes.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, start=0, err=0, state=IDLE, cmd_cnt=0, synchroniser flops=0; status therefore reads {core_busy,7'b0}.
- Strobe first sampled high at edge k -> byte consumed and registered outputs (wr_en/start/err/state) valid after edge k+3. Fixed 3-cycle latency.
- Host contract: data_in stable from 1 cycle before strobe rise until 4 cycles after; strobe high ≥3 cycles and low ≥3 cycles. Max throughput one byte per 6 cycles.
- wr_en and start are single-cycle pulses; never asserted on the same cycle.
- RUN uses core_busy sampled on the consuming cycle.
- Reset mid-LOAD: abort, no further writes, return to IDLE; partially written bytes remain in scratch.
- Pointer wraps from 2^ADDR_W-1 to 0 within one LOAD with no error.
- ena low mid-LOAD: FSM holds state; stream resumes on the next edge after ena returns high.

## Structure
- Shared package snpu_pkg: opcode constants (OP_LOAD=8'h1A, OP_RUN=8'h2B, OP_CLRERR=8'h3C), FSM state enum, status bit positions.
- One sub-module: snpu_sync_edge (2-flop synchroniser plus rising-edge pulse, async active-low reset); reused later for other asynchronous pin inputs.

## Test plan
- Reset with strobe held high, then release -> no byte consumed, all outputs at reset values, status=8'h00 with core_busy=0.
- LOAD 0x1A,0x05,0x03,0xAA,0xBB,0xCC -> three wr_en pulses at addr 5,6,7 with data AA,BB,CC; state back to IDLE; cmd_cnt=1.
- LOAD addr 0x3E count 3 (ADDR_W=6) -> writes at 0x3E,0x3F,0x00; err stays 0.
- RUN with core_busy=0 -> one start pulse 3 cycles after strobe; RUN with core_busy=1 -> no start, status[6]=1; CLRERR -> err=0.
- Illegal opcode 0x55 -> err=1, state IDLE, cmd_cnt unchanged; following LOAD still executes correctly.
- Assert rst_n low after the second data byte of a 4-byte LOAD -> outputs reset immediately; next RUN starts normally with no stray writes.
